// File: rtl/ddr5_sched_pkg.sv
// DDR5 scheduler shared types: request ops, mapped address fields,
// queue entries and address bit positions.
package ddr5_sched_pkg;

  localparam int ADDR_W = 34;
  localparam int CORE_W = 4;
  localparam int AGE_W  = 10;

  localparam int BYTE_LSB   = 0;
  localparam int BYTE_W     = 2;
  localparam int COL_LO_LSB = 2;
  localparam int COL_LO_W   = 4;
  localparam int CH_BIT     = 6;
  localparam int BG_LSB     = 7;
  localparam int BG_W       = 3;
  localparam int BANK_LSB   = 10;
  localparam int BANK_W     = 2;
  localparam int COL_HI_LSB = 12;
  localparam int COL_HI_W   = 6;
  localparam int ROW_LSB    = 18;
  localparam int ROW_W      = ADDR_W - ROW_LSB;
  localparam int COL_W      = COL_HI_W + COL_LO_W;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2
  } req_op_e;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BG_W-1:0]   bank_group;
    logic [BANK_W-1:0] bank;
    logic              channel;
    logic [COL_W-1:0]  column;
    logic [BYTE_W-1:0] byte_sel;
  } mapped_addr_t;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    req_op_e           op;
    mapped_addr_t      map;
    logic [AGE_W-1:0]  age;
  } queue_entry_t;

  function automatic logic [AGE_W-1:0] age_inc(
    input logic [AGE_W-1:0] a
  );
    return (a == '1) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/ddr5_req_queue_if.sv
// Request-queue handshake bundle: enqueue side from the trace
// front-end, removal side from the command scheduler.
interface ddr5_req_queue_if
  import ddr5_sched_pkg::*;
#(
  parameter int DEPTH = 16
) ();

  logic                     enq_valid;
  logic                     enq_ready;
  logic [CORE_W-1:0]        enq_core;
  req_op_e                  enq_op;
  logic [ADDR_W-1:0]        enq_addr;
  logic                     deq_valid;
  logic [$clog2(DEPTH)-1:0] deq_idx;

  modport master (
    output enq_valid, enq_core, enq_op,
    output enq_addr, deq_valid, deq_idx,
    input  enq_ready
  );

  modport slave (
    input  enq_valid, enq_core, enq_op,
    input  enq_addr, deq_valid, deq_idx,
    output enq_ready
  );

endinterface

// File: rtl/ddr5_addr_map.sv
// Physical address to DDR5 channel/bank-group/bank/row/column
// decode; purely combinational so other units can share it.
module ddr5_addr_map
  import ddr5_sched_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output mapped_addr_t      map
);

  assign map.byte_sel   = addr[BYTE_LSB +: BYTE_W];
  assign map.channel    = addr[CH_BIT];
  assign map.bank_group = addr[BG_LSB +: BG_W];
  assign map.bank       = addr[BANK_LSB +: BANK_W];
  assign map.row        = addr[ROW_LSB +: ROW_W];
  assign map.column     = {addr[COL_HI_LSB +: COL_HI_W],
                           addr[COL_LO_LSB +: COL_LO_W]};

endmodule

// File: rtl/ddr5_req_queue.sv
// DDR5 pending-request queue: age-ordered compacting slots with
// per-slot age counters and starvation flag on the oldest entry.
module ddr5_req_queue
  import ddr5_sched_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AGE_LIMIT = 500
) (
  input  logic                       clock,
  input  logic                       reset_n,
  ddr5_req_queue_if.slave            req,
  output logic [DEPTH-1:0]           slot_valid,
  output queue_entry_t [DEPTH-1:0]   slot_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       starve,
  output logic                       drop,
  output logic                       bad_deq
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  queue_entry_t [DEPTH-1:0] slots_q;
  queue_entry_t [DEPTH-1:0] slots_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] cnt_mid;
  logic [CW-1:0] cnt_nxt;
  logic          ready_q;
  logic          full_q;
  logic          empty_q;
  logic          drop_q;
  logic          bad_q;
  logic          deq_ok;
  logic          enq_ok;
  mapped_addr_t  enq_map;
  queue_entry_t  new_e;

  ddr5_addr_map u_map (
    .addr (req.enq_addr),
    .map  (enq_map)
  );

  always_comb begin
    deq_ok = req.deq_valid && (CW'(req.deq_idx) < count_q);
    enq_ok = req.enq_valid && ready_q;
    cnt_mid = count_q - CW'(deq_ok);
    cnt_nxt = cnt_mid + CW'(enq_ok);
    new_e = '0;
    new_e.core = req.enq_core;
    new_e.op   = req.enq_op;
    new_e.map  = enq_map;
    slots_d = '0;
    // removal compacts first; the new entry then lands on the tail
    for (int i = 0; i < DEPTH; i++) begin
      if (deq_ok && IW'(i) >= req.deq_idx)
        slots_d[i] = slots_q[(i == DEPTH-1) ? i : i+1];
      else
        slots_d[i] = slots_q[i];
      slots_d[i].age = age_inc(slots_d[i].age);
      if (CW'(i) >= cnt_mid)
        slots_d[i] = '0;
      if (enq_ok && CW'(i) == cnt_mid)
        slots_d[i] = new_e;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slots_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      drop_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      slots_q <= slots_d;
      count_q <= cnt_nxt;
      ready_q <= cnt_nxt != CW'(DEPTH);
      full_q  <= cnt_nxt == CW'(DEPTH);
      empty_q <= cnt_nxt == '0;
      drop_q  <= req.enq_valid && !ready_q;
      bad_q   <= req.deq_valid && !deq_ok;
    end
  end

  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++)
      slot_valid[i] = CW'(i) < count_q;
  end

  assign req.enq_ready = ready_q;
  assign slot_data     = slots_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign drop          = drop_q;
  assign bad_deq       = bad_q;
  assign starve        = slot_valid[0] &&
    (32'(slots_q[0].age) >= 32'(AGE_LIMIT));

endmodule

// File: tb/tb_ddr5_req_queue.sv
// Randomised bench for ddr5_req_queue against a queue-based
// reference model, plus directed corner sequences.
module tb_ddr5_req_queue;
  import ddr5_sched_pkg::*;

  localparam int DEPTH = 16;
  localparam int LIM   = 8;
  localparam int AMAX  = (1 << AGE_W) - 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int core;
    int op;
    int age;
  } m_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [DEPTH-1:0] slot_valid;
  queue_entry_t [DEPTH-1:0] slot_data;
  logic [4:0] count;
  logic full, empty, starve, drop, bad_deq;

  int checks = 0;
  int errors = 0;
  m_t mq[$];
  bit exp_drop = 0;
  bit exp_bad = 0;

  ddr5_req_queue_if #(.DEPTH(DEPTH)) req ();

  ddr5_req_queue #(.DEPTH(DEPTH), .AGE_LIMIT(LIM)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .slot_valid (slot_valid),
    .slot_data  (slot_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .starve     (starve),
    .drop       (drop),
    .bad_deq    (bad_deq)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mapped_addr_t ref_map(logic [ADDR_W-1:0] a);
    longint unsigned v = 64'(a);
    mapped_addr_t m;
    m.byte_sel   = 2'(v % 4);
    m.channel    = 1'((v / 64) % 2);
    m.bank_group = 3'((v / 128) % 8);
    m.bank       = 2'((v / 1024) % 4);
    m.column     = 10'(((v / 4096) % 64) * 16 + (v / 4) % 16);
    m.row        = 16'(v / 262144);
    return m;
  endfunction

  function automatic queue_entry_t mk(m_t m);
    queue_entry_t e;
    e.core = 4'(m.core);
    e.op   = req_op_e'(2'(m.op));
    e.map  = ref_map(m.addr);
    e.age  = 10'(m.age);
    return e;
  endfunction

  task automatic check_all();
    logic [DEPTH-1:0] v = '0;
    queue_entry_t e;
    int n = mq.size();
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    check("count", 64'(count), 64'(n));
    check("full", 64'(full), 64'(n == DEPTH));
    check("empty", 64'(empty), 64'(n == 0));
    check("enq_ready", 64'(req.enq_ready), 64'(n != DEPTH));
    check("slot_valid", 64'(slot_valid), 64'(v));
    for (int i = 0; i < DEPTH; i++) begin
      e = (i < n) ? mk(mq[i]) : '0;
      check($sformatf("slot%0d", i), 64'(slot_data[i]), 64'(e));
    end
    check("starve", 64'(starve),
          64'(n > 0 && mq[0].age >= LIM));
    check("drop", 64'(drop), 64'(exp_drop));
    check("bad_deq", 64'(bad_deq), 64'(exp_bad));
  endtask

  task automatic model(bit ev, int core, int op,
                       logic [ADDR_W-1:0] addr, bit dv, int idx);
    bit was_full = (mq.size() == DEPTH);
    m_t m;
    exp_drop = ev && was_full;
    exp_bad  = dv && idx >= mq.size();
    foreach (mq[i])
      if (mq[i].age < AMAX) mq[i].age++;
    if (dv && idx < mq.size()) mq.delete(idx);
    if (ev && !was_full) begin
      m.addr = addr; m.core = core; m.op = op; m.age = 0;
      mq.push_back(m);
    end
  endtask

  task automatic step(bit ev, int core, int op,
                      logic [ADDR_W-1:0] addr, bit dv, int idx);
    @(negedge clock);
    req.enq_valid = ev;
    req.enq_core  = 4'(core);
    req.enq_op    = req_op_e'(2'(op));
    req.enq_addr  = addr;
    req.deq_valid = dv;
    req.deq_idx   = 4'(idx);
    @(posedge clock);
    model(ev, core, op, addr, dv, idx);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0);
  endtask

  function automatic logic [ADDR_W-1:0] raddr();
    return ADDR_W'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    @(negedge clock);
    req.enq_valid = 0;
    req.deq_valid = 0;
    reset_n = 0;
    mq.delete();
    exp_drop = 0;
    exp_bad = 0;
    #1;
    check_all();
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    logic [ADDR_W-1:0] a0 = 34'h1_2345_6789;
    int c1;
    req.enq_valid = 0;
    req.enq_core  = '0;
    req.enq_op    = OP_READ;
    req.enq_addr  = '0;
    req.deq_valid = 0;
    req.deq_idx   = '0;
    #12;
    check_all();
    @(negedge clock);
    reset_n = 1;

    step(1, 3, 0, a0, 0, 0);
    check("ex_row", 64'(slot_data[0].map.row), 64'(16'h48D1));
    check("ex_bg", 64'(slot_data[0].map.bank_group), 64'(3'b111));
    check("ex_bank", 64'(slot_data[0].map.bank), 64'(2'b01));
    check("ex_ch", 64'(slot_data[0].map.channel), 64'(0));
    check("ex_byte", 64'(slot_data[0].map.byte_sel), 64'(1));
    check("ex_col", 64'(slot_data[0].map.column),
          64'(ref_map(a0).column));

    for (int i = 0; i < 7; i++) idle();
    check("starve_pre", 64'(starve), 64'(0));
    idle();
    check("starve_on", 64'(starve), 64'(1));
    step(0, 0, 0, '0, 1, 0);
    check("starve_off", 64'(starve), 64'(0));

    for (int i = 0; i < DEPTH; i++)
      step(1, i % 16, i % 3, raddr(), 0, 0);
    check("fill_full", 64'(full), 64'(1));
    step(1, 9, 1, raddr(), 0, 0);
    check("ovf_drop", 64'(drop), 64'(1));
    check("ovf_count", 64'(count), 64'(DEPTH));
    step(1, 9, 1, raddr(), 1, 0);
    check("fulldeq_count", 64'(count), 64'(DEPTH - 1));
    idle();
    check("drop_once", 64'(drop), 64'(0));

    do_reset();
    for (int i = 0; i < 5; i++) step(1, i + 1, 0, raddr(), 0, 0);
    step(0, 0, 0, '0, 1, 2);
    check("deq2_s2", 64'(slot_data[2].core), 64'(4));
    check("deq2_v4", 64'(slot_valid[4]), 64'(0));
    c1 = int'(slot_data[1].core);
    step(1, 12, 2, raddr(), 1, 0);
    check("ed_count", 64'(count), 64'(4));
    check("ed_s3", 64'(slot_data[3].core), 64'(12));
    check("ed_s0", 64'(slot_data[0].core), 64'(c1));
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 1, 6);
    check("bad_pulse", 64'(bad_deq), 64'(1));

    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 15),
           $urandom_range(0, 2), raddr(),
           $urandom_range(0, 9) < 4, $urandom_range(0, 15));

    if (mq.size() == 0) step(1, 5, 1, raddr(), 0, 0);
    for (int n = 0; n < AMAX + 5; n++) idle();
    check("age_sat", 64'(slot_data[0].age), 64'(AMAX));

    for (int i = 0; i < 3; i++) step(1, i, 0, raddr(), 0, 0);
    do_reset();
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
